// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus a counted burst of left/right
// shifts (serial fill or rotate) with a busy/done handshake.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter int               CW        = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic [CW-1:0]    shift_cnt,
    input  logic             dir,
    input  logic             rotate,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic             rot_q,   rot_d;

    logic             fill_right;
    logic             fill_left;
    logic [WIDTH-1:0] shifted;

    // Burst direction and mode come from the values latched at start.
    assign fill_right = rot_q ? data_q[0]       : ser_in;
    assign fill_left  = rot_q ? data_q[WIDTH-1] : ser_in;
    assign shifted    = dir_q ? {data_q[WIDTH-2:0], fill_left}
                              : {fill_right, data_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            data_q  <= RESET_VAL;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    data_d = din;
                end else if (start) begin
                    cnt_d   = shift_cnt;
                    dir_d   = dir;
                    rot_d   = rotate;
                    state_d = (shift_cnt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                data_d = shifted;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign q       = data_q;
    assign ser_out = dir_q ? data_q[WIDTH-1] : data_q[0];
    assign busy    = (state_q == ST_SHIFT);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: reset, a per-cycle vector table, a mid-burst
// reset sequence and randomized bursts against a shift-by-rule model.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          load;
    logic [W-1:0]  din;
    logic          start;
    logic [CW-1:0] shift_cnt;
    logic          dir;
    logic          rotate;
    logic          ser_in;
    logic [W-1:0]  q;
    logic          ser_out;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    univ_shift_reg #(.WIDTH(W), .CW(CW), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .load      (load),
        .din       (din),
        .start     (start),
        .shift_cnt (shift_cnt),
        .dir       (dir),
        .rotate    (rotate),
        .ser_in    (ser_in),
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          load;
        logic [W-1:0]  din;
        logic          start;
        logic [CW-1:0] cnt;
        logic          dir;
        logic          rot;
        logic          ser;
        logic [W-1:0]  exp_q;
        logic          exp_busy;
        logic          exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 1'b0; din = '0; start = 1'b0; shift_cnt = '0;
        dir = 1'b0; rotate = 1'b0; ser_in = 1'b0;
    endtask

    task automatic add(input logic ld, input logic [W-1:0] d, input logic st,
                       input logic [CW-1:0] c, input logic dr, input logic rt,
                       input logic s, input logic [W-1:0] eq,
                       input logic eb, input logic ed);
        vec_t v;
        v.load = ld; v.din = d; v.start = st; v.cnt = c; v.dir = dr;
        v.rot = rt; v.ser = s; v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    // One shift of the reference register, written from the shift rules.
    function automatic logic [W-1:0] model_shift(input logic [W-1:0] v,
                                                 input logic d, input logic r,
                                                 input logic s);
        int fill;
        int val;
        val = int'(v);
        if (!d) begin
            fill = r ? (val % 2) : int'(s);
            return W'((val / 2) + fill * (1 << (W-1)));
        end else begin
            fill = r ? ((val >> (W-1)) % 2) : int'(s);
            return W'(((val * 2) % (1 << W)) + fill);
        end
    endfunction

    initial begin
        logic [W-1:0] m;
        logic         rd, rr;
        int           n;

        idle_inputs();
        reset_L = 1'b0;

        // Reset dominates load and start.
        load = 1'b1; start = 1'b1; din = 8'hFF; shift_cnt = 4'd3;
        step();
        step();
        check("reset_q", q, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ser_out", ser_out, 1'b0);
        idle_inputs();
        reset_L = 1'b1;
        step();
        check("post_reset_q", q, 8'h00);

        // Per-cycle vectors: inputs driven before the edge, outputs checked after.
        add(1, 8'hA5, 0, 0, 0, 0, 0, 8'hA5, 0, 0);
        add(0, 8'h00, 1, 3, 0, 0, 1, 8'hA5, 1, 0);
        add(1, 8'h00, 1, 7, 1, 1, 1, 8'hD2, 1, 0);  // load/start mid-burst ignored
        add(0, 8'h00, 0, 0, 1, 1, 1, 8'hE9, 1, 0);  // dir/rotate change ignored
        add(0, 8'h00, 0, 0, 0, 0, 1, 8'hF4, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 8'hF4, 0, 0);
        add(1, 8'h81, 0, 0, 0, 0, 0, 8'h81, 0, 0);
        add(0, 8'h00, 1, 1, 1, 1, 0, 8'h81, 1, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 8'h03, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 8'h03, 0, 0);
        add(0, 8'h00, 1, 8, 1, 1, 0, 8'h03, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h06, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h0C, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h18, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h30, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h60, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'hC0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h81, 1, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 8'h03, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 8'h03, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 8'h03, 0, 1);  // zero-length burst
        add(0, 8'h00, 0, 0, 0, 0, 0, 8'h03, 0, 0);
        add(1, 8'h3C, 1, 2, 0, 0, 0, 8'h3C, 0, 0);  // load beats start
        add(0, 8'h00, 0, 0, 0, 0, 0, 8'h3C, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            load = vecs[i].load; din = vecs[i].din; start = vecs[i].start;
            shift_cnt = vecs[i].cnt; dir = vecs[i].dir; rotate = vecs[i].rot;
            ser_in = vecs[i].ser;
            step();
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
        end
        idle_inputs();

        // Reset after 2 of 5 shifts abandons the burst without a done pulse.
        load = 1'b1; din = 8'h5A; step();
        load = 1'b0; start = 1'b1; shift_cnt = 4'd5; ser_in = 1'b0; step();
        start = 1'b0; step(); step();
        check("midrst_pre_q", q, 8'h16);
        reset_L = 1'b0; step();
        check("midrst_q", q, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        reset_L = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("midrst_idle%0d_busy", i), busy, 1'b0);
            check($sformatf("midrst_idle%0d_done", i), done, 1'b0);
            check($sformatf("midrst_idle%0d_q", i), q, 8'h00);
        end

        // Randomized bursts with noise on control inputs during the burst.
        for (int b = 0; b < 60; b++) begin
            m = W'($urandom);
            load = 1'b1; din = m; step();
            check($sformatf("rnd%0d_load", b), q, m);
            n  = int'($urandom_range(0, (1 << CW) - 1));
            rd = 1'($urandom); rr = 1'($urandom);
            load = 1'b0; start = 1'b1; shift_cnt = CW'(n); dir = rd; rotate = rr;
            step();
            start = 1'b0;
            for (int i = 0; i < n; i++) begin
                check($sformatf("rnd%0d_s%0d_busy", b, i), busy, 1'b1);
                check($sformatf("rnd%0d_s%0d_done", b, i), done, 1'b0);
                check($sformatf("rnd%0d_s%0d_q", b, i), q, m);
                check($sformatf("rnd%0d_s%0d_so", b, i), ser_out, rd ? m[W-1] : m[0]);
                ser_in = 1'($urandom);
                load = 1'($urandom); start = 1'($urandom); din = W'($urandom);
                shift_cnt = CW'($urandom); dir = 1'($urandom); rotate = 1'($urandom);
                step();
                m = model_shift(m, rd, rr, ser_in);
            end
            idle_inputs();
            check($sformatf("rnd%0d_done", b), done, 1'b1);
            check($sformatf("rnd%0d_done_busy", b), busy, 1'b0);
            check($sformatf("rnd%0d_final_q", b), q, m);
            step();
            check($sformatf("rnd%0d_after_done", b), done, 1'b0);
            check($sformatf("rnd%0d_after_q", b), q, m);
            $display("burst %0d n=%0d dir=%0d rot=%0d q=0x%02h", b, n, rd, rr, q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
